// File: rtl/sbox_lane_sched.sv
// Shares one 32-bit S-box lane between cipher-state SubBytes (4 column passes) and key SubWord.
// Optional SBOX_LANE_STATS_EN adds a saturating stall counter output.
module sbox_lane_sched #(
    parameter int unsigned KEY_PRIO = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_dat_valid,
    output logic         o_dat_ready,
    input  logic [127:0] i_dat_in,
    output logic         o_dat_out_valid,
    output logic [127:0] o_dat_out,
    input  logic         i_key_valid,
    output logic         o_key_ready,
    input  logic [31:0]  i_key_in,
    output logic         o_key_out_valid,
    output logic [31:0]  o_key_out,
    output logic [31:0]  o_sb_in,
    input  logic [31:0]  i_sb_out,
    output logic         o_busy
`ifdef SBOX_LANE_STATS_EN
   ,output logic [15:0]  o_stall_cnt
`endif
);

    typedef enum logic {DIdle, DRun} dstate_e;
    typedef enum logic {KIdle, KPend} kstate_e;

    dstate_e      r_dstate;
    dstate_e      w_dstate_nxt;
    kstate_e      r_kstate;
    kstate_e      w_kstate_nxt;

    logic         r_live;
    logic [127:0] r_dat;
    logic [1:0]   r_col;
    logic         r_col_done;
    logic [31:0]  r_key;
    logic [127:0] r_dat_out;
    logic         r_dat_out_valid;
    logic [31:0]  r_key_out;
    logic         r_key_out_valid;
    logic         r_last_key;

    logic         w_dat_acc;
    logic         w_key_acc;
    logic         w_dat_req;
    logic         w_key_req;
    logic         w_both;
    logic         w_gnt_key;
    logic         w_gnt_dat;
    logic         w_last_col;
    logic [31:0]  w_col_word;

    assign w_dat_acc = i_dat_valid && o_dat_ready;
    assign w_key_acc = i_key_valid && o_key_ready;

    // Lane arbitration; r_last_key resets to 0 so key wins the first contended cycle.
    always_comb begin
        w_dat_req = (r_dstate == DRun) && !r_col_done;
        w_key_req = (r_kstate == KPend);
        w_both    = w_dat_req && w_key_req;
        if (w_both) begin
            w_gnt_key = (KEY_PRIO != 0) ? 1'b1 : !r_last_key;
        end else begin
            w_gnt_key = w_key_req;
        end
        w_gnt_dat  = w_dat_req && !w_gnt_key;
        w_last_col = w_gnt_dat && (r_col == 2'd3);
    end

    always_comb begin
        case (r_col)
            2'd0:    w_col_word = r_dat[31:0];
            2'd1:    w_col_word = r_dat[63:32];
            2'd2:    w_col_word = r_dat[95:64];
            default: w_col_word = r_dat[127:96];
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dstate <= DIdle;
            r_kstate <= KIdle;
        end else begin
            r_dstate <= w_dstate_nxt;
            r_kstate <= w_kstate_nxt;
        end
    end

    always_comb begin
        w_dstate_nxt = r_dstate;
        w_kstate_nxt = r_kstate;
        case (r_dstate)
            DIdle:   if (w_dat_acc) w_dstate_nxt = DRun;
            default: if (w_last_col) w_dstate_nxt = DIdle;
        endcase
        case (r_kstate)
            KIdle:   if (w_key_acc) w_kstate_nxt = KPend;
            default: if (w_gnt_key) w_kstate_nxt = KIdle;
        endcase
    end

    // r_live holds the ready outputs low while reset is asserted.
    always_comb begin
        o_dat_ready = r_live && (r_dstate == DIdle);
        o_key_ready = r_live && (r_kstate == KIdle);
        o_busy      = (r_dstate == DRun) || (r_kstate == KPend);
        o_sb_in     = 32'h0;
        if (w_gnt_key) begin
            o_sb_in = r_key;
        end else if (w_gnt_dat) begin
            o_sb_in = w_col_word;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_live          <= 1'b0;
            r_dat           <= 128'h0;
            r_col           <= 2'd0;
            r_col_done      <= 1'b0;
            r_key           <= 32'h0;
            r_dat_out       <= 128'h0;
            r_dat_out_valid <= 1'b0;
            r_key_out       <= 32'h0;
            r_key_out_valid <= 1'b0;
            r_last_key      <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_dat_acc) begin
                r_dat      <= i_dat_in;
                r_col      <= 2'd0;
                r_col_done <= 1'b0;
            end else if (w_gnt_dat) begin
                case (r_col)
                    2'd0:    r_dat[31:0]   <= i_sb_out;
                    2'd1:    r_dat[63:32]  <= i_sb_out;
                    2'd2:    r_dat[95:64]  <= i_sb_out;
                    default: r_dat[127:96] <= i_sb_out;
                endcase
                r_col      <= r_col + 2'd1;
                r_col_done <= (r_col == 2'd3);
            end

            // Separate result register keeps dat_out stable while the next block runs.
            r_dat_out_valid <= w_last_col;
            if (w_last_col) begin
                r_dat_out <= {i_sb_out, r_dat[95:0]};
            end

            if (w_key_acc) begin
                r_key <= i_key_in;
            end
            r_key_out_valid <= w_gnt_key;
            if (w_gnt_key) begin
                r_key_out <= i_sb_out;
            end

            if (w_gnt_key) begin
                r_last_key <= 1'b1;
            end else if (w_gnt_dat) begin
                r_last_key <= 1'b0;
            end
        end
    end

    assign o_dat_out_valid = r_dat_out_valid;
    assign o_dat_out       = r_dat_out;
    assign o_key_out_valid = r_key_out_valid;
    assign o_key_out       = r_key_out;

`ifdef SBOX_LANE_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= 16'h0;
        end else if (w_both && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_sbox_lane_sched.sv
// Bench for sbox_lane_sched: one instance per KEY_PRIO value, AES S-box lane model,
// vector table, corner-case sequences and a randomized run against a transaction-level model.
module tb_sbox_lane_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         dv_0, dv_1, kv_0, kv_1;
    logic [127:0] din_0, din_1;
    logic [31:0]  kin_0, kin_1;
    logic         dr_0, dr_1, dov_0, dov_1, kr_0, kr_1, kov_0, kov_1, busy_0, busy_1;
    logic [127:0] dout_0, dout_1;
    logic [31:0]  kout_0, kout_1, sbi_0, sbi_1, sbo_0, sbo_1;
`ifdef SBOX_LANE_STATS_EN
    logic [15:0]  stall_0, stall_1;
`endif

    typedef struct {
        logic         dr;
        logic         dov;
        logic [127:0] dout;
        logic         kr;
        logic         kov;
        logic [31:0]  kout;
        logic [31:0]  sbi;
        logic         busy;
        logic [15:0]  stall;
    } out_t;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dexp;
        logic [31:0]  kin;
        logic [31:0]  kexp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // AES S-box from first principles: inverse in GF(2^8) then the affine map.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(w[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] sub128(input logic [127:0] b);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) r[32*c +: 32] = subword(b[32*c +: 32]);
        return r;
    endfunction

    assign sbo_0 = subword(sbi_0);
    assign sbo_1 = subword(sbi_1);

    sbox_lane_sched #(.KEY_PRIO(0)) u_dut_p0 (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_dat_valid     (dv_0),
        .o_dat_ready     (dr_0),
        .i_dat_in        (din_0),
        .o_dat_out_valid (dov_0),
        .o_dat_out       (dout_0),
        .i_key_valid     (kv_0),
        .o_key_ready     (kr_0),
        .i_key_in        (kin_0),
        .o_key_out_valid (kov_0),
        .o_key_out       (kout_0),
        .o_sb_in         (sbi_0),
        .i_sb_out        (sbo_0),
        .o_busy          (busy_0)
`ifdef SBOX_LANE_STATS_EN
       ,.o_stall_cnt     (stall_0)
`endif
    );

    sbox_lane_sched #(.KEY_PRIO(1)) u_dut_p1 (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_dat_valid     (dv_1),
        .o_dat_ready     (dr_1),
        .i_dat_in        (din_1),
        .o_dat_out_valid (dov_1),
        .o_dat_out       (dout_1),
        .i_key_valid     (kv_1),
        .o_key_ready     (kr_1),
        .i_key_in        (kin_1),
        .o_key_out_valid (kov_1),
        .o_key_out       (kout_1),
        .o_sb_in         (sbi_1),
        .i_sb_out        (sbo_1),
        .o_busy          (busy_1)
`ifdef SBOX_LANE_STATS_EN
       ,.o_stall_cnt     (stall_1)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    task automatic sample(input int p, output out_t o);
        o.stall = 16'h0;
        if (p == 0) begin
            o.dr = dr_0; o.dov = dov_0; o.dout = dout_0; o.kr = kr_0; o.kov = kov_0;
            o.kout = kout_0; o.sbi = sbi_0; o.busy = busy_0;
`ifdef SBOX_LANE_STATS_EN
            o.stall = stall_0;
`endif
        end else begin
            o.dr = dr_1; o.dov = dov_1; o.dout = dout_1; o.kr = kr_1; o.kov = kov_1;
            o.kout = kout_1; o.sbi = sbi_1; o.busy = busy_1;
`ifdef SBOX_LANE_STATS_EN
            o.stall = stall_1;
`endif
        end
    endtask

    task automatic drive(input int p, input logic dv, input logic [127:0] din, input logic kv,
                         input logic [31:0] kin);
        if (p == 0) begin
            dv_0 = dv; din_0 = din; kv_0 = kv; kin_0 = kin;
        end else begin
            dv_1 = dv; din_1 = din; kv_1 = kv; kin_1 = kin;
        end
    endtask

    // Transaction-level reference model, one slot per KEY_PRIO value.
    bit           m_dpend   [2];
    int           m_dcols   [2];
    logic [127:0] m_dblk    [2];
    bit           m_kpend   [2];
    logic [31:0]  m_kword   [2];
    bit           m_last_key[2];
    bit           m_dpulse  [2];
    bit           m_kpulse  [2];
    logic [127:0] m_dout    [2];
    logic [31:0]  m_kout    [2];
    int           m_stall   [2];

    task automatic model_reset(input int p);
        m_dpend[p] = 0; m_dcols[p] = 0; m_dblk[p] = '0; m_kpend[p] = 0; m_kword[p] = '0;
        m_last_key[p] = 0; m_dpulse[p] = 0; m_kpulse[p] = 0; m_dout[p] = '0; m_kout[p] = '0;
        m_stall[p] = 0;
    endtask

    task automatic model_grant(input int p, output bit gk, output bit gd);
        gk = m_kpend[p] && (!m_dpend[p] || p == 1 || !m_last_key[p]);
        gd = m_dpend[p] && !gk;
    endtask

    task automatic model_check(input int p);
        out_t         o;
        bit           gk, gd;
        logic [31:0]  esb;
        logic [127:0] blk;
        string        t;
        t = $sformatf("rand p%0d", p);
        sample(p, o);
        model_grant(p, gk, gd);
        blk = m_dblk[p];
        esb = gk ? m_kword[p] : (gd ? blk[32*m_dcols[p] +: 32] : 32'h0);
        chk({t, " sb_in"}, 128'(o.sbi), 128'(esb));
        chk1({t, " dat_ready"}, o.dr, !m_dpend[p]);
        chk1({t, " key_ready"}, o.kr, !m_kpend[p]);
        chk1({t, " busy"}, o.busy, m_dpend[p] || m_kpend[p]);
        chk1({t, " dat_out_valid"}, o.dov, m_dpulse[p]);
        chk1({t, " key_out_valid"}, o.kov, m_kpulse[p]);
        if (m_dpulse[p]) chk({t, " dat_out"}, o.dout, m_dout[p]);
        if (m_kpulse[p]) chk({t, " key_out"}, 128'(o.kout), 128'(m_kout[p]));
`ifdef SBOX_LANE_STATS_EN
        chk({t, " stall_cnt"}, 128'(o.stall), 128'(m_stall[p]));
`endif
    endtask

    task automatic model_step(input int p, input logic dv, input logic [127:0] din,
                              input logic kv, input logic [31:0] kin);
        bit gk, gd, rd, rk, both;
        model_grant(p, gk, gd);
        rd   = !m_dpend[p];
        rk   = !m_kpend[p];
        both = m_dpend[p] && m_kpend[p];
        m_dpulse[p] = gd && (m_dcols[p] == 3);
        if (m_dpulse[p]) begin
            m_dout[p]  = sub128(m_dblk[p]);
            m_dpend[p] = 0;
        end
        if (gd) m_dcols[p]++;
        m_kpulse[p] = gk;
        if (gk) begin
            m_kout[p]  = subword(m_kword[p]);
            m_kpend[p] = 0;
        end
        if (gk) m_last_key[p] = 1;
        else if (gd) m_last_key[p] = 0;
        if (both && m_stall[p] < 65535) m_stall[p]++;
        if (dv && rd) begin
            m_dpend[p] = 1; m_dblk[p] = din; m_dcols[p] = 0;
        end
        if (kv && rk) begin
            m_kpend[p] = 1; m_kword[p] = kin;
        end
    endtask

    task automatic chk_zero(input int p, input string t);
        out_t o;
        sample(p, o);
        chk1({t, " dat_ready"}, o.dr, 1'b0);
        chk1({t, " dat_out_valid"}, o.dov, 1'b0);
        chk({t, " dat_out"}, o.dout, 128'h0);
        chk1({t, " key_ready"}, o.kr, 1'b0);
        chk1({t, " key_out_valid"}, o.kov, 1'b0);
        chk({t, " key_out"}, 128'(o.kout), 128'h0);
        chk({t, " sb_in"}, 128'(o.sbi), 128'h0);
        chk1({t, " busy"}, o.busy, 1'b0);
        chk({t, " stall_cnt"}, 128'(o.stall), 128'h0);
    endtask

    // Asserts reset at the current time; returns at a negedge one cycle after release.
    task automatic do_reset();
        out_t o;
        drive(0, 1'b0, 128'h0, 1'b0, 32'h0);
        drive(1, 1'b0, 128'h0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) chk_zero(p, $sformatf("reset p%0d", p));
        @(negedge clk);
        @(negedge clk);
        for (int p = 0; p < 2; p++) chk_zero(p, $sformatf("reset hold p%0d", p));
        rst_n = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            sample(p, o);
            chk1($sformatf("post-reset p%0d dat_ready", p), o.dr, 1'b1);
            chk1($sformatf("post-reset p%0d key_ready", p), o.kr, 1'b1);
            model_reset(p);
        end
    endtask

    task automatic run_data(input int p, input logic [127:0] din, input logic [127:0] exp,
                            input string tag);
        out_t o;
        for (int k = 0; k <= 6; k++) begin
            sample(p, o);
            chk1({tag, " dat_ready"}, o.dr, (k == 0) || (k >= 5));
            chk1({tag, " dat_out_valid"}, o.dov, k == 5);
            if (k >= 1 && k <= 4) chk({tag, " sb_in"}, 128'(o.sbi), 128'(din[32*(k-1) +: 32]));
            if (k >= 5) chk({tag, " dat_out"}, o.dout, exp);
            drive(p, k == 0, din, 1'b0, 32'h0);
            @(negedge clk);
        end
    endtask

    task automatic run_key(input int p, input logic [31:0] kin, input logic [31:0] exp,
                           input string tag);
        out_t o;
        for (int k = 0; k <= 3; k++) begin
            sample(p, o);
            chk1({tag, " key_ready"}, o.kr, k != 1);
            chk1({tag, " key_out_valid"}, o.kov, k == 2);
            chk({tag, " sb_in"}, 128'(o.sbi), 128'((k == 1) ? kin : 32'h0));
            if (k == 2) chk({tag, " key_out"}, 128'(o.kout), 128'(exp));
            drive(p, 1'b0, 128'h0, k == 0, kin);
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl [4];
        out_t         o;
        logic [127:0] dvec;
        logic         rdv, rkv;
        logic [127:0] rdin;
        logic [31:0]  rkin;

        tbl[0] = '{128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816,
                   32'h09cf4f3c, 32'h018a84eb};
        tbl[1] = '{128'h0, {4{32'h63636363}}, 32'h01010101, 32'h7c7c7c7c};
        tbl[2] = '{{4{32'hffffffff}}, {4{32'h16161616}}, 32'hffffffff, 32'h16161616};
        tbl[3] = '{{32'h01010101, 32'h53535353, 32'hffffffff, 32'h00000000},
                   {32'h7c7c7c7c, 32'hedededed, 32'h16161616, 32'h63636363},
                   32'h00000000, 32'h63636363};

        rst_n = 1'b1;
        drive(0, 1'b0, 128'h0, 1'b0, 32'h0);
        drive(1, 1'b0, 128'h0, 1'b0, 32'h0);
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < 2; p++) begin
                run_data(p, tbl[i].din, tbl[i].dexp, $sformatf("vec%0d p%0d data", i, p));
                run_key(p, tbl[i].kin, tbl[i].kexp, $sformatf("vec%0d p%0d key", i, p));
            end
        end

        // KEY_PRIO=1: key arrives mid-block and steals one lane cycle.
        do_reset();
        for (int k = 0; k <= 7; k++) begin
            sample(1, o);
            chk1("prio1 dat_out_valid", o.dov, k == 6);
            chk1("prio1 key_out_valid", o.kov, k == 4);
            if (k == 4) chk("prio1 key_out", 128'(o.kout), 128'(tbl[0].kexp));
            if (k == 6) chk("prio1 dat_out", o.dout, tbl[0].dexp);
            drive(1, k == 0, tbl[0].din, k == 2, tbl[0].kin);
            @(negedge clk);
        end
`ifdef SBOX_LANE_STATS_EN
        sample(1, o);
        chk("prio1 stall_cnt", 128'(o.stall), 128'd1);
`endif

        // KEY_PRIO=0: simultaneous accept, key goes first after reset.
        do_reset();
        dvec = tbl[0].din;
        for (int k = 0; k <= 7; k++) begin
            sample(0, o);
            chk("prio0 sb_in", 128'(o.sbi),
                128'((k == 1) ? tbl[0].kin : ((k >= 2 && k <= 5) ? dvec[32*(k-2) +: 32] : 32'h0)));
            chk1("prio0 key_out_valid", o.kov, k == 2);
            chk1("prio0 dat_out_valid", o.dov, k == 6);
            if (k == 6) chk("prio0 dat_out", o.dout, tbl[0].dexp);
            drive(0, k == 0, tbl[0].din, k == 0, tbl[0].kin);
            @(negedge clk);
        end
`ifdef SBOX_LANE_STATS_EN
        sample(0, o);
        chk("prio0 stall_cnt", 128'(o.stall), 128'd1);
`endif

        // Back-to-back blocks: second accepted in the first's completion cycle.
        for (int k = 0; k <= 11; k++) begin
            sample(1, o);
            chk1("b2b dat_out_valid", o.dov, (k == 5) || (k == 10));
            if (k == 5 || k == 10) chk1("b2b dat_ready", o.dr, 1'b1);
            if (k >= 5 && k <= 9) chk("b2b dat_out first", o.dout, tbl[0].dexp);
            if (k >= 10) chk("b2b dat_out second", o.dout, tbl[3].dexp);
            drive(1, (k == 0) || (k == 5), (k == 0) ? tbl[0].din : tbl[3].din, 1'b0, 32'h0);
            @(negedge clk);
        end

        // Reset two cycles into a block abandons it; the next block runs normally.
        for (int k = 0; k <= 1; k++) begin
            sample(1, o);
            if (k == 1) chk1("midreset busy", o.busy, 1'b1);
            drive(1, k == 0, tbl[2].din, 1'b0, 32'h0);
            @(negedge clk);
        end
        do_reset();
        run_data(1, tbl[1].din, tbl[1].dexp, "after midreset");

        // Randomized traffic against the reference model.
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int p = 0; p < 2; p++) model_check(p);
            for (int p = 0; p < 2; p++) begin
                rdv  = ($urandom_range(0, 2) == 0);
                rdin = {$urandom, $urandom, $urandom, $urandom};
                rkv  = ($urandom_range(0, 3) == 0);
                rkin = $urandom;
                drive(p, rdv, rdin, rkv, rkin);
                model_step(p, rdv, rdin, rkv, rkin);
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
